// File: rtl/demux_1to2_if.sv
// demux_1to2_if: stream bundle for the 1:2 demultiplexer.
// One valid/ready input stream with a destination select, and two
// valid/ready output streams. The slave modport is the demux side.
// Optional per-channel accept counters exist when DEMUX_1TO2_COUNT_EN is defined.
interface demux_1to2_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned CNT_W = 16;

  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
`ifdef DEMUX_1TO2_COUNT_EN
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
`endif

  modport slave (
    input  in_valid, in_sel, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
`ifdef DEMUX_1TO2_COUNT_EN
    , output cnt0, cnt1
`endif
  );

  modport master (
    output in_valid, in_sel, in_data, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
`ifdef DEMUX_1TO2_COUNT_EN
    , input cnt0, cnt1
`endif
  );
endinterface

// File: rtl/demux_1to2.sv
// demux_1to2: registered 1:2 stream demultiplexer.
// Each output channel has a one-entry holding register; a transfer accepted
// at one edge is presented the following cycle. A blocked input stalls all
// traffic (head-of-line blocking). Define DEMUX_1TO2_COUNT_EN to add
// 16-bit wrapping per-channel accept counters (cnt0/cnt1).
module demux_1to2 #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  demux_1to2_if.slave  bus
);
  localparam int unsigned CNT_W = 16;

  logic             full0;
  logic             full1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             in_ready_c;
  logic             acc0;
  logic             acc1;
  logic             drain0;
  logic             drain1;

  // Input ready looks only at the selected channel; the selected channel can
  // take a new beat if it is empty or is draining this cycle.
  always_comb begin
    in_ready_c = 1'b0;
    acc0       = 1'b0;
    acc1       = 1'b0;
    drain0     = full0 & bus.out0_ready;
    drain1     = full1 & bus.out1_ready;
    if (bus.in_sel) begin
      in_ready_c = !full1 | bus.out1_ready;
    end else begin
      in_ready_c = !full0 | bus.out0_ready;
    end
    acc0 = bus.in_valid & in_ready_c & !bus.in_sel;
    acc1 = bus.in_valid & in_ready_c &  bus.in_sel;
  end

  // Holding registers: load on accept, clear full on drain unless reloaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full0 <= 1'b0;
      full1 <= 1'b0;
      data0 <= '0;
      data1 <= '0;
    end else begin
      if (acc0) begin
        data0 <= bus.in_data;
        full0 <= 1'b1;
      end else if (drain0) begin
        full0 <= 1'b0;
      end
      if (acc1) begin
        data1 <= bus.in_data;
        full1 <= 1'b1;
      end else if (drain1) begin
        full1 <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out0_valid = full0;
  assign bus.out0_data  = data0;
  assign bus.out1_valid = full1;
  assign bus.out1_data  = data1;

`ifdef DEMUX_1TO2_COUNT_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // Per-channel accept counters, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (acc0) cnt0_q <= cnt0_q + CNT_W'(1);
      if (acc1) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;
`endif

endmodule

// File: doc/demux_1to2.md
# demux_1to2

Registered 1:2 stream demultiplexer, the inverse of the catalog's 2:1 mux. Each transfer on a single valid/ready input stream goes to one of two output streams, chosen by a select bit sampled with the data. Each output has a one-entry holding register, so the block decouples producer and consumers with one cycle of latency. It is the routing element for splitting a datapath, for example issue to two functional units or write-back to two register banks.

## Interface
- WIDTH, 32, data width in bits (≥1)
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- in_valid  in  1  input transfer offered
- in_ready  out  1  block can accept the offered transfer
- in_sel  in  1  destination: 0 → channel 0, 1 → channel 1; meaningful only when in_valid=1
- in_data  in  WIDTH  input payload
- out0_valid  out  1  channel 0 holds a transfer
- out0_ready  in  1  channel 0 consumer accepts
- out0_data  out  WIDTH  channel 0 payload
- out1_valid  out  1  channel 1 holds a transfer
- out1_ready  in  1  channel 1 consumer accepts
- out1_data  out  WIDTH  channel 1 payload
- cnt0  out  16  channel 0 accepted-transfer count; present only with DEMUX_1TO2_COUNT_EN
- cnt1  out  16  channel 1 accepted-transfer count; present only with DEMUX_1TO2_COUNT_EN

## Operation
- Per channel k, state is a full flag `full_k` (drives outk_valid) and a data register (drives outk_data).
- Input handshake: in_ready = !full[in_sel] | outk_ready, where k = in_sel.
  - in_ready is combinational from in_sel, the full flags and the selected out_ready.
  - in_ready does not depend on in_valid.
  - The non-selected channel has no effect on in_ready.
- Accept: in_valid & in_ready. The selected channel's data register loads in_data, and its full flag sets next cycle.
- Drain on channel k: outk_valid & outk_ready. full_k clears next cycle unless the same channel is reloaded that cycle.
- Accept into k and drain of k in the same cycle: register reloads and full_k stays 1. This gives full throughput of 1 transfer per cycle per channel.
- Accept into k while channel j≠k drains: both events take effect independently.
- Stall: while outk_valid=1 and outk_ready=0, outk_data and outk_valid hold stable.
- Data registers load only on accept. Data is not cleared on drain.
- The block never drops or duplicates a transfer, and order is preserved within each channel.
- An input stalled on a full channel blocks all input (head-of-line blocking), even if the other channel is empty.

## Timing
- Reset values (rst_n=0 at a clock edge): out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, cnt0=0, cnt1=0.
- During and after reset, in_ready = 1 for either in_sel, because both channels are empty.
- Reset mid-operation flushes held transfers; they are lost without being presented.
- An accept in the same cycle as an active reset is discarded.
- Latency: a transfer accepted at edge N appears on outk_valid/outk_data in the cycle after edge N. The earliest drain is at edge N+1.
- Combinational paths: in_sel and outk_ready → in_ready only. No path from in_* to out*_valid or out*_data.

## Configuration
- DEMUX_1TO2_COUNT_EN defined:
  - cnt0/cnt1 ports exist.
  - cntk increments by 1 on each accept into channel k.
  - Counters wrap from 16'hFFFF to 16'h0000 and reset to 0.
- Not defined: cnt0/cnt1 ports and counter logic are absent. Handshake behaviour is identical in both builds.

## Test plan
- Reset, then one transfer in_sel=0, in_data=32'hA5A5_0001, out0_ready=1:
  - out0_valid=1 with that data for exactly one cycle, one cycle after accept.
  - out1_valid stays 0.
- Back-to-back streaming, in_sel alternating 0/1 with data 1..8, both readies held 1:
  - in_ready stays 1.
  - Channel 0 sees 1,3,5,7 and channel 1 sees 2,4,6,8, in order, one per accepting cycle.
- Backpressure with out1_ready=0:
  - Send 32'h11 to ch1, then offer 32'h22 to ch1: in_ready=0 and out1_data holds 32'h11.
  - Switch offer to ch0 with 32'h33: accepted.
  - Raise out1_ready: 32'h11 drains, then 32'h22 is accepted.
- Full channel with simultaneous drain, out0_ready=1 and continuous in_sel=0 traffic 32'h40..32'h47: in_ready=1 every cycle and there are no bubbles on out0_valid.
- Reset mid-operation with both channels full (out*_ready=0), rst_n=0 for one edge:
  - out0_valid=out1_valid=0 and data=0 next cycle, then in_ready=1.
  - With DEMUX_1TO2_COUNT_EN, cnt0=cnt1=0.
- Counter wrap (DEMUX_1TO2_COUNT_EN): 65,536 accepts to ch0 → cnt0 returns to 0 and cnt1 stays 0.
